// File: rtl/gyro_uart_pkg.sv
// Shared constants and state types for the gyro telemetry UART receiver.
// Frame: six axis bytes (x_lo..z_hi) followed by a run of sync bytes.
package gyro_uart_pkg;

    localparam logic [7:0] SYNC_BYTE  = 8'h55;
    localparam int         DATA_BYTES = 6;
    localparam int         FRAME_LEN  = 12;

    typedef enum logic [2:0] {
        BIT_IDLE,
        BIT_START,
        BIT_DATA,
        BIT_STOP,
        BIT_BREAK
    } bit_state_t;

    typedef enum logic [1:0] {
        ASM_HUNT,
        ASM_DATA,
        ASM_TRAIL
    } asm_state_t;

endpackage

// File: rtl/gyro_uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchronizer plus mid-bit sampling FSM.
// Emits byte_valid on a good stop bit, frame_err on a low stop bit.
module uart_rx_byte
    import gyro_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    logic            rx_meta_q, rx_s_q;
    bit_state_t      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      byte_data_q, byte_data_d;
    logic            byte_valid_q, byte_valid_d;
    logic            frame_err_q, frame_err_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= BIT_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_meta_q    <= rx;
            rx_s_q       <= rx_meta_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_data_d  = byte_data_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            BIT_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = BIT_START;
            end
            BIT_START: begin
                // Half-bit check rejects glitches and centres later samples.
                if (cnt_q == HALF_CNT) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s_q ? BIT_IDLE : BIT_DATA;
                end
            end
            BIT_DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) state_d = BIT_STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            BIT_STOP: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        byte_data_d  = shift_q;
                        byte_valid_d = 1'b1;
                        state_d      = BIT_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BIT_BREAK;
                    end
                end
            end
            BIT_BREAK: begin
                cnt_d = '0;
                if (rx_s_q) state_d = BIT_IDLE;
            end
            default: state_d = BIT_IDLE;
        endcase
    end

    assign byte_data  = byte_data_q;
    assign byte_valid = byte_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: rtl/gyro_uart_rx.sv
// Gyro telemetry receiver: byte receiver plus sync-locked frame assembler.
// Optional GYRO_RX_FRAMECNT_EN adds a wrapping frame_count output.
module gyro_uart_rx
    import gyro_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int SYNC_MIN     = FRAME_LEN - DATA_BYTES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    output logic        frame_err,
    output logic        locked,
    output logic [15:0] x_axis,
    output logic [15:0] y_axis,
    output logic [15:0] z_axis,
`ifdef GYRO_RX_FRAMECNT_EN
    output logic [15:0] frame_count,
`endif
    output logic        frame_valid
);

    localparam int SW = $clog2(SYNC_MIN + 1);
    localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_MIN);

    asm_state_t    state_q, state_d;
    logic [SW-1:0] sync_cnt_q, sync_cnt_d, sync_inc;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shadow_q [DATA_BYTES];
    logic [7:0]    shadow_d [DATA_BYTES];
    logic [15:0]   x_q, x_d, y_q, y_d, z_q, z_d;
    logic          locked_q, locked_d;
    logic          frame_valid_q, frame_valid_d;
`ifdef GYRO_RX_FRAMECNT_EN
    logic [15:0]   frame_count_q, frame_count_d;
`endif

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ASM_HUNT;
            sync_cnt_q    <= '0;
            idx_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            z_q           <= '0;
            locked_q      <= 1'b0;
            frame_valid_q <= 1'b0;
            for (int i = 0; i < DATA_BYTES; i++) shadow_q[i] <= '0;
`ifdef GYRO_RX_FRAMECNT_EN
            frame_count_q <= '0;
`endif
        end else begin
            state_q       <= state_d;
            sync_cnt_q    <= sync_cnt_d;
            idx_q         <= idx_d;
            x_q           <= x_d;
            y_q           <= y_d;
            z_q           <= z_d;
            locked_q      <= locked_d;
            frame_valid_q <= frame_valid_d;
            for (int i = 0; i < DATA_BYTES; i++) shadow_q[i] <= shadow_d[i];
`ifdef GYRO_RX_FRAMECNT_EN
            frame_count_q <= frame_count_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        sync_cnt_d    = sync_cnt_q;
        idx_d         = idx_q;
        x_d           = x_q;
        y_d           = y_q;
        z_d           = z_q;
        locked_d      = locked_q;
        frame_valid_d = 1'b0;
        for (int i = 0; i < DATA_BYTES; i++) shadow_d[i] = shadow_q[i];
        sync_inc = (sync_cnt_q == SYNC_LAST) ? sync_cnt_q : sync_cnt_q + 1'b1;

        if (frame_err) begin
            state_d    = ASM_HUNT;
            sync_cnt_d = '0;
            idx_d      = '0;
            locked_d   = 1'b0;
            for (int i = 0; i < DATA_BYTES; i++) shadow_d[i] = '0;
        end else if (byte_valid) begin
            case (state_q)
                ASM_HUNT, ASM_TRAIL: begin
                    if (byte_data == SYNC_BYTE) begin
                        sync_cnt_d = sync_inc;
                        if (sync_inc == SYNC_LAST) begin
                            state_d    = ASM_DATA;
                            idx_d      = '0;
                            sync_cnt_d = '0;
                            locked_d   = 1'b1;
                        end
                    end else begin
                        sync_cnt_d = '0;
                        state_d    = ASM_HUNT;
                        locked_d   = 1'b0;
                    end
                end
                ASM_DATA: begin
                    shadow_d[idx_q] = byte_data;
                    idx_d           = idx_q + 3'd1;
                    // Last byte bypasses the shadow so axes update atomically next cycle.
                    if (idx_q == 3'(DATA_BYTES - 1)) begin
                        x_d           = {shadow_q[1], shadow_q[0]};
                        y_d           = {shadow_q[3], shadow_q[2]};
                        z_d           = {byte_data, shadow_q[4]};
                        frame_valid_d = 1'b1;
                        sync_cnt_d    = '0;
                        state_d       = ASM_TRAIL;
                    end
                end
                default: state_d = ASM_HUNT;
            endcase
        end
`ifdef GYRO_RX_FRAMECNT_EN
        frame_count_d = frame_valid_d ? frame_count_q + 16'd1 : frame_count_q;
`endif
    end

    assign locked      = locked_q;
    assign x_axis      = x_q;
    assign y_axis      = y_q;
    assign z_axis      = z_q;
    assign frame_valid = frame_valid_q;
`ifdef GYRO_RX_FRAMECNT_EN
    assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_gyro_uart_rx.sv
// Self-checking bench for gyro_uart_rx with CLKS_PER_BIT=4 and a byte/frame scoreboard.
// Frame-count checks are active when GYRO_RX_FRAMECNT_EN is defined.
module tb_gyro_uart_rx;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx = 1'b1;
    logic [7:0]  byte_data;
    logic        byte_valid, frame_err, locked, frame_valid;
    logic [15:0] x_axis, y_axis, z_axis;
`ifdef GYRO_RX_FRAMECNT_EN
    logic [15:0] frame_count;
`endif

    int vectors = 0;
    int miscompares = 0;
    int n_bv = 0, n_fe = 0, n_fv = 0;
    logic [7:0]  exp_bytes[$];
    logic [47:0] exp_frames[$];
    logic [15:0] exp_fcnt = 16'd0;

    always #5 clk = ~clk;

    gyro_uart_rx #(.CLKS_PER_BIT(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .frame_err   (frame_err),
        .locked      (locked),
        .x_axis      (x_axis),
        .y_axis      (y_axis),
        .z_axis      (z_axis),
`ifdef GYRO_RX_FRAMECNT_EN
        .frame_count (frame_count),
`endif
        .frame_valid (frame_valid)
    );

    // Advance one cycle and score any strobe the DUT produced.
    task automatic tick();
        logic [7:0]  eb;
        logic [47:0] ef;
        @(negedge clk);
        if (byte_valid === 1'b1) begin
            n_bv++;
            vectors++;
            if (exp_bytes.size() == 0) begin
                miscompares++;
                $display("FAIL byte_unexpected got=%h required=none", byte_data);
            end else begin
                eb = exp_bytes.pop_front();
                if (byte_data !== eb) begin
                    miscompares++;
                    $display("FAIL byte_data got=%h required=%h", byte_data, eb);
                end else $display("byte %h", byte_data);
            end
        end
        if (frame_err === 1'b1) begin
            n_fe++;
            $display("frame_err strobe");
        end
        if (frame_valid === 1'b1) begin
            n_fv++;
            vectors++;
            if (exp_frames.size() == 0) begin
                miscompares++;
                $display("FAIL frame_unexpected got=%h_%h_%h required=none", x_axis, y_axis, z_axis);
            end else begin
                ef = exp_frames.pop_front();
                if ({x_axis, y_axis, z_axis} !== ef) begin
                    miscompares++;
                    $display("FAIL frame_axes got=%h_%h_%h required=%h_%h_%h",
                             x_axis, y_axis, z_axis, ef[47:32], ef[31:16], ef[15:0]);
                end else $display("frame x=%h y=%h z=%h", x_axis, y_axis, z_axis);
            end
`ifdef GYRO_RX_FRAMECNT_EN
            exp_fcnt = exp_fcnt + 16'd1;
            vectors++;
            if (frame_count !== exp_fcnt) begin
                miscompares++;
                $display("FAIL frame_count got=%0d required=%0d", frame_count, exp_fcnt);
            end
`endif
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) tick();
    endtask

    // abort_at >= 0 stops driving two cycles into that data bit.
    task automatic send_byte(input logic [7:0] b, input logic stop, input bit expect_ok, input int abort_at);
        if (expect_ok) exp_bytes.push_back(b);
        rx = 1'b0;
        repeat (N) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == abort_at) begin
                tick();
                tick();
                return;
            end
            repeat (N) tick();
        end
        rx = stop;
        repeat (N) tick();
        rx = 1'b1;
    endtask

    task automatic send_sync(input int n);
        for (int i = 0; i < n; i++) send_byte(8'h55, 1'b1, 1'b1, -1);
    endtask

    task automatic send_frame(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        exp_frames.push_back({x, y, z});
        send_byte(x[7:0], 1'b1, 1'b1, -1);
        send_byte(x[15:8], 1'b1, 1'b1, -1);
        send_byte(y[7:0], 1'b1, 1'b1, -1);
        send_byte(y[15:8], 1'b1, 1'b1, -1);
        send_byte(z[7:0], 1'b1, 1'b1, -1);
        send_byte(z[15:8], 1'b1, 1'b1, -1);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle(4);
        vectors++;
        if ({byte_data, byte_valid, frame_err, locked, x_axis, y_axis, z_axis, frame_valid} !== 60'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%h required=0",
                     {byte_data, byte_valid, frame_err, locked, x_axis, y_axis, z_axis, frame_valid});
        end
        reset = 1'b1;
        idle(4);
    endtask

    task automatic test_single_byte();
        int bv0 = n_bv;
        int fe0 = n_fe;
        send_byte(8'hA3, 1'b1, 1'b1, -1);
        idle(8);
        vectors++;
        if (n_bv - bv0 != 1) begin
            miscompares++;
            $display("FAIL single_byte_count got=%0d required=1", n_bv - bv0);
        end
        vectors++;
        if (n_fe != fe0 || locked !== 1'b0) begin
            miscompares++;
            $display("FAIL single_byte_flags got=fe%0d,locked%b required=fe0,locked0", n_fe - fe0, locked);
        end
    endtask

    task automatic test_lock_frame();
        int fv0 = n_fv;
        send_sync(5);
        idle(6);
        vectors++;
        if (locked !== 1'b0) begin
            miscompares++;
            $display("FAIL lock_after_5 got=%b required=0", locked);
        end
        send_sync(1);
        idle(6);
        vectors++;
        if (locked !== 1'b1) begin
            miscompares++;
            $display("FAIL lock_after_6 got=%b required=1", locked);
        end
        send_frame(16'h1234, 16'h5678, 16'h9ABC);
        idle(8);
        vectors++;
        if (n_fv - fv0 != 1 || exp_frames.size() != 0) begin
            miscompares++;
            $display("FAIL frame1_count got=%0d required=1", n_fv - fv0);
        end
        send_sync(6);
        idle(6);
    endtask

    task automatic test_all_sync_data();
        int fv0 = n_fv;
        send_frame(16'h5555, 16'h5555, 16'h5555);
        idle(8);
        vectors++;
        if (n_fv - fv0 != 1 || locked !== 1'b1) begin
            miscompares++;
            $display("FAIL sync_data_frame got=fv%0d,locked%b required=fv1,locked1", n_fv - fv0, locked);
        end
        send_sync(6);
        idle(6);
    endtask

    task automatic test_stop_error();
        int fv0 = n_fv;
        int fe0 = n_fe;
        send_byte(8'h01, 1'b1, 1'b1, -1);
        send_byte(8'h02, 1'b1, 1'b1, -1);
        send_byte(8'h03, 1'b1, 1'b1, -1);
        send_byte(8'h04, 1'b1, 1'b1, -1);
        send_byte(8'hEE, 1'b0, 1'b0, -1);
        idle(12);
        vectors++;
        if (n_fe - fe0 != 1 || n_fv != fv0) begin
            miscompares++;
            $display("FAIL stop_err_strobes got=fe%0d,fv%0d required=fe1,fv0", n_fe - fe0, n_fv - fv0);
        end
        vectors++;
        if (locked !== 1'b0) begin
            miscompares++;
            $display("FAIL stop_err_locked got=%b required=0", locked);
        end
        vectors++;
        if ({x_axis, y_axis, z_axis} !== 48'h5555_5555_5555) begin
            miscompares++;
            $display("FAIL stop_err_axes got=%h_%h_%h required=5555_5555_5555", x_axis, y_axis, z_axis);
        end
        send_sync(6);
        idle(6);
        vectors++;
        if (locked !== 1'b1) begin
            miscompares++;
            $display("FAIL relock got=%b required=1", locked);
        end
    endtask

    task automatic test_glitch();
        int bv0 = n_bv;
        int fe0 = n_fe;
        idle(4);
        rx = 1'b0;
        tick();
        idle(20);
        vectors++;
        if (n_bv != bv0 || n_fe != fe0) begin
            miscompares++;
            $display("FAIL glitch got=bv%0d,fe%0d required=bv0,fe0", n_bv - bv0, n_fe - fe0);
        end
    endtask

    task automatic test_reset_mid_byte();
        int fv0;
        send_byte(8'h11, 1'b1, 1'b1, -1);
        send_byte(8'h22, 1'b1, 1'b1, -1);
        send_byte(8'h33, 1'b1, 1'b1, -1);
        send_byte(8'h44, 1'b1, 1'b1, -1);
        send_byte(8'hBC, 1'b1, 1'b0, 4);
        reset = 1'b0;
        rx = 1'b1;
        tick();
        vectors++;
        if ({byte_data, byte_valid, frame_err, locked, x_axis, y_axis, z_axis, frame_valid} !== 60'd0) begin
            miscompares++;
            $display("FAIL midreset_outputs got=%h required=0",
                     {byte_data, byte_valid, frame_err, locked, x_axis, y_axis, z_axis, frame_valid});
        end
`ifdef GYRO_RX_FRAMECNT_EN
        vectors++;
        if (frame_count !== 16'd0) begin
            miscompares++;
            $display("FAIL midreset_count got=%0d required=0", frame_count);
        end
        exp_fcnt = 16'd0;
`endif
        tick();
        reset = 1'b1;
        idle(6);
        fv0 = n_fv;
        send_sync(6);
        send_frame(16'h2211, 16'h4433, 16'h6655);
        idle(8);
        vectors++;
        if (n_fv - fv0 != 1 || locked !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_frame got=fv%0d,locked%b required=fv1,locked1", n_fv - fv0, locked);
        end
`ifdef GYRO_RX_FRAMECNT_EN
        vectors++;
        if (frame_count !== 16'd1) begin
            miscompares++;
            $display("FAIL post_reset_count got=%0d required=1", frame_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_lock_frame();
        test_all_sync_data();
        test_stop_error();
        test_glitch();
        test_reset_mid_byte();
        vectors++;
        if (exp_bytes.size() != 0 || exp_frames.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got=%0d/%0d required=0/0", exp_bytes.size(), exp_frames.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
